// File: rtl/writeback_buffer_if.sv
// ============================================================================
// Module      : writeback_buffer_if
// Description : Bus bundle for the writeback buffer.
//               master : producer / register-file side (drives requests,
//                        stall and lookup addresses)
//               slave  : the buffer itself (drives ready, write port,
//                        lookup results and status)
// Ports       : none (signals only); parameter DEPTH sizes the Count field.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

interface writeback_buffer_if #(
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  // Producer request
  logic          Wb_Valid;
  logic          Wb_Ready;
  logic [4:0]    Wb_Addr;
  logic [31:0]   Wb_Data;

  // Register-file write port
  logic          Rf_Stall;
  logic          Rf_Wr_En;
  logic [4:0]    Rf_Write_Addr;
  logic [31:0]   Rf_Write_Data;

  // Bypass queries
  logic [4:0]    Lookup_Addr_1;
  logic [4:0]    Lookup_Addr_2;
  logic          Lookup_Hit_1;
  logic          Lookup_Hit_2;
  logic [31:0]   Lookup_Data_1;
  logic [31:0]   Lookup_Data_2;

  // Status
  logic [CW-1:0] Count;
  logic          Full;
  logic          Empty;

  modport master (
    output Wb_Valid, Wb_Addr, Wb_Data, Rf_Stall, Lookup_Addr_1, Lookup_Addr_2,
    input  Wb_Ready, Rf_Wr_En, Rf_Write_Addr, Rf_Write_Data,
           Lookup_Hit_1, Lookup_Hit_2, Lookup_Data_1, Lookup_Data_2,
           Count, Full, Empty
  );

  modport slave (
    input  Wb_Valid, Wb_Addr, Wb_Data, Rf_Stall, Lookup_Addr_1, Lookup_Addr_2,
    output Wb_Ready, Rf_Wr_En, Rf_Write_Addr, Rf_Write_Data,
           Lookup_Hit_1, Lookup_Hit_2, Lookup_Data_1, Lookup_Data_2,
           Count, Full, Empty
  );
endinterface

`default_nettype wire

// File: rtl/writeback_buffer.sv
// ============================================================================
// Module      : writeback_buffer
// Description : In-order FIFO of pending register writebacks with a
//               registered register-file write stage and two combinational
//               bypass lookup ports (newest queued entry wins, then the
//               write stage).
// Ports       : Clk_Core  - core clock
//               Rst_Core  - synchronous active-high reset
//               bus       - writeback_buffer_if.slave (request, write port,
//                           lookups, Count/Full/Empty)
// Parameters  : DEPTH     - number of entries, power of 2 in 2..16
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module writeback_buffer #(
  parameter int DEPTH = 4
) (
  input  wire logic         Clk_Core,
  input  wire logic         Rst_Core,
  writeback_buffer_if.slave bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] c_DEPTH_CNT = CW'(DEPTH);

  // Entry storage; only slots between head and head+count are meaningful,
  // so the array itself needs no reset.
  logic [4:0]    r_addr [DEPTH];
  logic [31:0]   r_data [DEPTH];

  logic [AW-1:0] r_head;
  logic [AW-1:0] r_tail;
  logic [CW-1:0] r_count;

  logic          r_wr_en;
  logic [4:0]    r_wr_addr;
  logic [31:0]   r_wr_data;

  logic          w_ready;
  logic          w_push;
  logic          w_pop;

  logic          w_hit_1;
  logic          w_hit_2;
  logic [31:0]   w_data_1;
  logic [31:0]   w_data_2;

  // Ready looks only at the current count, so a full buffer refuses a
  // request even when it is popping in the same cycle.
  assign w_ready = (r_count < c_DEPTH_CNT);
  // Writes to x0 are accepted (handshake completes) but never stored.
  assign w_push  = bus.Wb_Valid && w_ready && (bus.Wb_Addr != 5'd0);
  assign w_pop   = (r_count != '0) && !bus.Rf_Stall;

  // Storage write
  always_ff @(posedge Clk_Core) begin
    if (!Rst_Core && w_push) begin
      r_addr[r_tail] <= bus.Wb_Addr;
      r_data[r_tail] <= bus.Wb_Data;
    end
  end

  // Pointers and occupancy; pointer width makes the wrap modulo DEPTH.
  always_ff @(posedge Clk_Core) begin
    if (Rst_Core) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_tail <= r_tail + AW'(1);
      end
      if (w_pop) begin
        r_head <= r_head + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Register-file write stage: address/data hold between pops.
  always_ff @(posedge Clk_Core) begin
    if (Rst_Core) begin
      r_wr_en   <= 1'b0;
      r_wr_addr <= 5'd0;
      r_wr_data <= 32'd0;
    end else begin
      r_wr_en <= w_pop;
      if (w_pop) begin
        r_wr_addr <= r_addr[r_head];
        r_wr_data <= r_data[r_head];
      end
    end
  end

  // Bypass lookup. Start from the write stage (lowest priority), then walk
  // the queue oldest to newest so the newest matching entry overrides.
  always_comb begin
    logic [AW-1:0] w_idx;
    w_idx    = '0;
    w_hit_1  = (bus.Lookup_Addr_1 != 5'd0) && r_wr_en &&
               (r_wr_addr == bus.Lookup_Addr_1);
    w_data_1 = w_hit_1 ? r_wr_data : 32'd0;
    w_hit_2  = (bus.Lookup_Addr_2 != 5'd0) && r_wr_en &&
               (r_wr_addr == bus.Lookup_Addr_2);
    w_data_2 = w_hit_2 ? r_wr_data : 32'd0;
    for (int i = 0; i < DEPTH; i++) begin
      w_idx = r_head + AW'(i);
      if (CW'(i) < r_count) begin
        if ((bus.Lookup_Addr_1 != 5'd0) && (r_addr[w_idx] == bus.Lookup_Addr_1)) begin
          w_hit_1  = 1'b1;
          w_data_1 = r_data[w_idx];
        end
        if ((bus.Lookup_Addr_2 != 5'd0) && (r_addr[w_idx] == bus.Lookup_Addr_2)) begin
          w_hit_2  = 1'b1;
          w_data_2 = r_data[w_idx];
        end
      end
    end
  end

  assign bus.Wb_Ready      = w_ready;
  assign bus.Rf_Wr_En      = r_wr_en;
  assign bus.Rf_Write_Addr = r_wr_addr;
  assign bus.Rf_Write_Data = r_wr_data;
  assign bus.Lookup_Hit_1  = w_hit_1;
  assign bus.Lookup_Hit_2  = w_hit_2;
  assign bus.Lookup_Data_1 = w_data_1;
  assign bus.Lookup_Data_2 = w_data_2;
  assign bus.Count         = r_count;
  assign bus.Full          = (r_count == c_DEPTH_CNT);
  assign bus.Empty         = (r_count == '0);

endmodule

`default_nettype wire
